hbridge_sequencer: RTL and testbench

- Supervisory sequencer between the control laws (theta, phi, theta+phi, mixed) and the dead-time stage that drives the H-bridge.
- Replaces the ad-hoc start-up counters and gating around the bridge.
- Runs a fixed start-up sequence: bootstrap charge, then force sigma=1, then hands control to the selected control law.
- Inserts an all-off safe interval on control-law mode changes, and latches faults (external over-voltage/over-current, shoot-through request) until the operator clears them.

---
 rtl/hbridge_sequencer.sv | 177 +++++++++++++++++
 tb/tb_hbridge_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_sequencer.sv
// Supervisory sequencer for the H-bridge: bootstrap charge, forced sigma=1, then the selected control law.
// Latency 1 cycle input to output; no backpressure, and faults latch until the operator drops enable with the fault clear.
module hbridge_sequencer #(
    parameter int BOOT_CYCLES  = 1000,
    parameter int FORCE_CYCLES = 1000,
    parameter int SAFE_CYCLES  = 50,
    parameter int CNT_W        = 16
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    input  logic [3:0] i_MOSFET,
    input  logic       i_fault_ext,
    output logic [3:0] o_MOSFET,
    output logic [2:0] o_state,
    output logic       o_running,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [1:0] o_mode
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_FORCE = 3'd2,
        ST_RUN   = 3'd3,
        ST_SAFE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    // A zero-length phase still occupies one cycle, so its terminal count is 0.
    localparam logic [CNT_W-1:0] BOOT_LAST  = (BOOT_CYCLES  == 0) ? '0 : CNT_W'(BOOT_CYCLES  - 1);
    localparam logic [CNT_W-1:0] FORCE_LAST = (FORCE_CYCLES == 0) ? '0 : CNT_W'(FORCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAFE_LAST  = (SAFE_CYCLES  == 0) ? '0 : CNT_W'(SAFE_CYCLES  - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mosfet_q, mosfet_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       safe_mode_q, safe_mode_d;
    logic [1:0]       code_q, code_d;
    logic             running_q, running_d;
    logic             fault_q, fault_d;

    logic             shoot;
    logic             trig_st;
    logic             legal_st;
    logic             fault_now;

    assign shoot     = (i_MOSFET[0] & i_MOSFET[2]) | (i_MOSFET[1] & i_MOSFET[3]);
    assign trig_st   = (state_q == ST_RUN) & shoot;
    assign legal_st  = (state_q <= ST_SAFE);
    assign fault_now = legal_st & (i_fault_ext | trig_st);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        safe_mode_d = safe_mode_q;
        code_d      = code_q;

        if (fault_now) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            code_d  = {trig_st, i_fault_ext};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enable && (i_mode != 2'b11)) begin
                        mode_d  = i_mode;
                        cnt_d   = '0;
                        state_d = ST_BOOT;
                    end
                end
                ST_BOOT, ST_FORCE, ST_RUN: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (i_mode != mode_q) begin
                        state_d     = ST_SAFE;
                        cnt_d       = '0;
                        safe_mode_d = i_mode;
                    end else if (state_q == ST_BOOT) begin
                        if (cnt_q == BOOT_LAST) begin
                            state_d = ST_FORCE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (state_q == ST_FORCE) begin
                        if (cnt_q == FORCE_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SAFE: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (i_mode != safe_mode_q) begin
                        // Operator still moving the selector: restart the dwell.
                        cnt_d       = '0;
                        safe_mode_d = i_mode;
                    end else if (cnt_q == SAFE_LAST) begin
                        cnt_d = '0;
                        if (i_mode == 2'b11) begin
                            state_d = ST_IDLE;
                        end else begin
                            mode_d  = i_mode;
                            state_d = ST_BOOT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (!i_enable && !i_fault_ext) begin
                        state_d = ST_IDLE;
                        code_d  = 2'b00;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        mosfet_d  = 4'b0000;
        running_d = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
        case (state_d)
            ST_BOOT:  mosfet_d = 4'b1100;
            ST_FORCE: mosfet_d = 4'b1001;
            // Guards the FORCE->RUN edge, where a shoot-through request is not yet a fault.
            ST_RUN:   mosfet_d = shoot ? 4'b0000 : i_MOSFET;
            default:  mosfet_d = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mosfet_q    <= 4'b0000;
            mode_q      <= 2'b00;
            safe_mode_q <= 2'b00;
            code_q      <= 2'b00;
            running_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mosfet_q    <= mosfet_d;
            mode_q      <= mode_d;
            safe_mode_q <= safe_mode_d;
            code_q      <= code_d;
            running_q   <= running_d;
            fault_q     <= fault_d;
        end
    end

    assign o_MOSFET     = mosfet_q;
    assign o_state      = state_q;
    assign o_running    = running_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_mode       = mode_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Directed bench for hbridge_sequencer: start-up timing, faults, mode-change dwell, enable drop, async reset.
module tb_hbridge_sequencer;

    logic       i_clock = 1'b0;
    logic       i_RESET;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [3:0] i_MOSFET;
    logic       i_fault_ext;
    logic [3:0] o_MOSFET;
    logic [2:0] o_state;
    logic       o_running;
    logic       o_fault;
    logic [1:0] o_fault_code;
    logic [1:0] o_mode;

    int n_vec = 0;
    int n_err = 0;

    logic [12:0] act;
    logic [12:0] exp_v;

    hbridge_sequencer dut (
        .i_clock      (i_clock),
        .i_RESET      (i_RESET),
        .i_enable     (i_enable),
        .i_mode       (i_mode),
        .i_MOSFET     (i_MOSFET),
        .i_fault_ext  (i_fault_ext),
        .o_MOSFET     (o_MOSFET),
        .o_state      (o_state),
        .o_running    (o_running),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code),
        .o_mode       (o_mode)
    );

    always #5 i_clock = ~i_clock;

    assign act = {o_state, o_MOSFET, o_running, o_fault, o_fault_code, o_mode};

    // Expected output bundle: running/fault flags follow from the state code.
    function automatic logic [12:0] pk(input logic [2:0] st, input logic [3:0] mos,
                                       input logic [1:0] code, input logic [1:0] mode);
        return {st, mos, (st == 3'd3), (st == 3'd5), code, mode};
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic [1:0] md);
        i_RESET     = 1'b0;
        i_enable    = en;
        i_mode      = md;
        i_MOSFET    = 4'b0110;
        i_fault_ext = 1'b0;
        tick();
        tick();
        i_RESET = 1'b1;
    endtask

    // Called right after the edge that entered BOOT; walks BOOT, FORCE and the first RUN edge.
    task automatic seq_from_boot(input logic [1:0] md, input logic [3:0] mos);
        for (int j = 0; j < 2000; j++) begin
            exp_v = pk((j < 1000) ? 3'd1 : 3'd2, (j < 1000) ? 4'b1100 : 4'b1001, 2'b00, md);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL boot_force j=%0d act=%h exp=%h", j, act, exp_v);
                break;
            end
            tick();
        end
        exp_v = pk(3'd3, mos, 2'b00, md);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL run_entry act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, 2'b00);
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL reset act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_startup();
        do_reset(1'b0, 2'b00);
        tick();
        i_enable = 1'b1;
        tick();
        seq_from_boot(2'b00, 4'b0110);
        i_MOSFET = 4'b1001;
        tick();
        exp_v = pk(3'd3, 4'b1001, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL run_follow act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_shoot_through();
        i_MOSFET = 4'b0101;
        tick();
        i_MOSFET = 4'b0110;
        exp_v = pk(3'd5, 4'b0000, 2'b10, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL shoot_entry act=%h exp=%h", act, exp_v);
        end
        repeat (3) tick();
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL shoot_sticky act=%h exp=%h", act, exp_v);
        end
        i_enable = 1'b0;
        tick();
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL shoot_clear act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_ext_fault_boot();
        i_enable = 1'b1;
        tick();
        repeat (500) tick();
        i_fault_ext = 1'b1;
        tick();
        i_fault_ext = 1'b0;
        exp_v = pk(3'd5, 4'b0000, 2'b01, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL ext_entry act=%h exp=%h", act, exp_v);
        end
        repeat (2) tick();
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL ext_sticky act=%h exp=%h", act, exp_v);
        end
        i_enable    = 1'b0;
        i_fault_ext = 1'b1;
        tick();
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL ext_hold_while_fault act=%h exp=%h", act, exp_v);
        end
        i_fault_ext = 1'b0;
        tick();
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL ext_clear act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_both_faults();
        i_MOSFET = 4'b0110;
        i_enable = 1'b1;
        tick();
        seq_from_boot(2'b00, 4'b0110);
        i_MOSFET    = 4'b1010;
        i_fault_ext = 1'b1;
        tick();
        i_MOSFET    = 4'b0110;
        i_fault_ext = 1'b0;
        exp_v = pk(3'd5, 4'b0000, 2'b11, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL both_code act=%h exp=%h", act, exp_v);
        end
        i_enable = 1'b0;
        tick();
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL both_clear act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_mode_change();
        i_enable = 1'b1;
        i_mode   = 2'b00;
        tick();
        seq_from_boot(2'b00, 4'b0110);
        i_mode = 2'b01;
        for (int j = 0; j < 50; j++) begin
            tick();
            exp_v = pk(3'd4, 4'b0000, 2'b00, 2'b00);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL safe_dwell j=%0d act=%h exp=%h", j, act, exp_v);
                break;
            end
        end
        tick();
        seq_from_boot(2'b01, 4'b0110);
        // Second change, then another one mid-dwell that must restart the count.
        i_mode = 2'b10;
        tick();
        repeat (20) tick();
        i_mode = 2'b11;
        tick();
        for (int j = 0; j < 49; j++) begin
            tick();
            exp_v = pk(3'd4, 4'b0000, 2'b00, 2'b01);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL safe_restart j=%0d act=%h exp=%h", j, act, exp_v);
                break;
            end
        end
        tick();
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b01);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL safe_to_idle act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_enable_drop_force();
        do_reset(1'b0, 2'b00);
        i_enable = 1'b1;
        tick();
        repeat (1000) tick();
        exp_v = pk(3'd2, 4'b1001, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL force_reached act=%h exp=%h", act, exp_v);
        end
        repeat (10) tick();
        i_enable = 1'b0;
        tick();
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL force_drop act=%h exp=%h", act, exp_v);
        end
    endtask

    task automatic test_async_reset();
        i_enable = 1'b1;
        i_mode   = 2'b10;
        tick();
        repeat (100) tick();
        exp_v = pk(3'd1, 4'b1100, 2'b00, 2'b10);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL async_pre act=%h exp=%h", act, exp_v);
        end
        #2;
        i_RESET = 1'b0;
        #1;
        exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL async_reset act=%h exp=%h", act, exp_v);
        end
        tick();
        i_RESET  = 1'b1;
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_invalid_mode();
        do_reset(1'b1, 2'b11);
        for (int j = 0; j < 20; j++) begin
            tick();
            exp_v = pk(3'd0, 4'b0000, 2'b00, 2'b00);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL invalid_mode j=%0d act=%h exp=%h", j, act, exp_v);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_shoot_through();
        test_ext_fault_boot();
        test_both_faults();
        test_mode_change();
        test_enable_drop_force();
        test_async_reset();
        test_invalid_mode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
